l2_port_arbiter: RTL and testbench
==================================

// Module: l2_port_arbiter
// PURPOSE
//  Shares the single L1-side port of the L2 cache between two L1 requesters (port 0 = L1I, port 1 = L1D).
//  Round-robin grant, one L2 transaction in flight; holds request and data stable until the L2 completes.
//  Returns the L2 response to the granted requester and keeps per-port saturating grant counters.
//  Sits between the two L1 controllers and the L2 cache's L1 interface.
// PARAMETERS
//  DATA_WIDTH   32  bits per word
//  ADDR_WIDTH   11  address width, identical to the L2 address
//  BLOCK_SIZE   32  words per block; BLK_W = BLOCK_SIZE*DATA_WIDTH (flat vectors)
//  COUNT_WIDTH  16  width of each grant counter
// PORTS  (N = 0,1; one set of pN_* ports per requester)
//  clk             in   1           single clock, rising edge
//  rst             in   1           asynchronous, active-high reset
//  pN_addr         in   ADDR_WIDTH  requester block address
//  pN_data_in      in   BLK_W       write block
//  pN_read         in   1           read request, level, held until pN_ready
//  pN_write        in   1           write request, level, held until pN_ready
//  pN_ready        out  1           one-cycle completion pulse
//  pN_hit          out  1           L2 hit flag, valid with pN_ready
//  pN_block_valid  out  1           pN_block_out valid, with pN_ready
//  pN_block_out    out  BLK_W       returned block
//  l2_addr         out  ADDR_WIDTH  to L2 l1_cache_addr
//  l2_data_out     out  BLK_W       to L2 l1_cache_data_in
//  l2_read         out  1           to L2 l1_cache_read
//  l2_write        out  1           to L2 l1_cache_write
//  l2_ready        in   1           from L2 l1_cache_ready
//  l2_hit          in   1           from L2 l1_cache_hit
//  l2_block_valid  in   1           from L2 l1_block_valid
//  l2_block_data   in   BLK_W       from L2 l1_block_data_out
//  busy            out  1           transaction in flight (state == BUSY)
//  owner           out  1           granted port; valid while busy
//  grant_cnt0/1    out  COUNT_WIDTH saturating grant count per port
// BEHAVIOUR
//  Reset: all outputs, counters, latched addr/data/cmd = 0; state IDLE; round-robin pointer favours port 0.
//   Reset mid-transaction abandons the transaction silently. No response pulse is produced.
//  States: IDLE, BUSY.
//   IDLE: port N is eligible if (pN_read|pN_write) & !pN_ready.
//    - One eligible port: grant it.
//    - Both eligible: grant the pointer's port, then toggle the pointer to the other port.
//    - On grant: latch addr, data and cmd; owner <= N; grant_cntN++ (saturates at all-ones).
//    - On grant: go to BUSY. l2_read/l2_write go high the next cycle.
//   BUSY: l2_addr/l2_data_out/cmd are held from the latches.
//    - l2_read  = rd_q & !l2_ready.
//    - l2_write = wr_q & !l2_ready.
//    - The gating is combinational and exists so the L2 does not restart in its return-to-idle cycle.
//    - Cycle with l2_ready=1: on that edge load pOwner_ready=1, _hit=l2_hit, _block_valid=l2_block_valid,
//      _block_out=l2_block_data; go to IDLE.
//   pN_ready/_hit/_block_valid are one-cycle pulses. pN_block_out holds until the next response to that port.
//   The non-owner's outputs stay 0.
//  Command rule: if read and write are both asserted, the arbiter forwards write only (rd_q=0).
//  Latency from request to pN_ready, uncontended:
//   - 4 cycles for an L2 hit or any write.
//   - For a read miss: first mem_ready cycle + 2.
//  Back-to-back: a new grant is possible in the cycle pN_ready is high; the next L2 command lands one cycle later.
//  Requester contract: deassert the request the cycle after seeing pN_ready. A request still high then is a new request.
//  Requests that change while not granted are not latched. Only the values at the grant edge are used.
//  The arbiter has no timeout; a stalled L2 holds BUSY indefinitely.
// TESTING
//  - p0_read addr 0x040 to an L2 hit, p1 idle -> l2_read high in cycle 1, p0_ready/p0_hit/p0_block_valid=1 in cycle 4, p1_* stay 0.
//  - p0_read and p1_write asserted in the same cycle after reset -> p0 served first, p1 second.
//    A repeat of the same pair -> p1 served first (pointer alternates). grant_cnt0=grant_cnt1=2 afterwards.
//  - p1_read miss, mem_ready asserted 5 cycles after mem_read -> p1_block_out = memory block, p1_hit=0.
//    l2_read is never high in the L2 return-to-idle cycle.
//  - p0_read=p0_write=1 with data 0xA5.. -> only l2_write asserted; p0_ready with p0_block_out = written data.
//  - rst pulsed while BUSY -> all outputs 0 immediately; no pN_ready pulse; the next request is granted normally.
//  - COUNT_WIDTH=2, five p0 transactions -> grant_cnt0 saturates at 3.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Two-requester round-robin arbiter in front of the L2 cache's single L1-side port.
// One transaction in flight; the response is steered back to the granted port as a one-cycle pulse.
module l2_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int BLOCK_SIZE  = 32,
  parameter int COUNT_WIDTH = 16,
  localparam int BLK_W      = BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  p0_addr,
  input  logic [BLK_W-1:0]       p0_data_in,
  input  logic                   p0_read,
  input  logic                   p0_write,
  output logic                   p0_ready,
  output logic                   p0_hit,
  output logic                   p0_block_valid,
  output logic [BLK_W-1:0]       p0_block_out,
  input  logic [ADDR_WIDTH-1:0]  p1_addr,
  input  logic [BLK_W-1:0]       p1_data_in,
  input  logic                   p1_read,
  input  logic                   p1_write,
  output logic                   p1_ready,
  output logic                   p1_hit,
  output logic                   p1_block_valid,
  output logic [BLK_W-1:0]       p1_block_out,
  output logic [ADDR_WIDTH-1:0]  l2_addr,
  output logic [BLK_W-1:0]       l2_data_out,
  output logic                   l2_read,
  output logic                   l2_write,
  input  logic                   l2_ready,
  input  logic                   l2_hit,
  input  logic                   l2_block_valid,
  input  logic [BLK_W-1:0]       l2_block_data,
  output logic                   busy,
  output logic                   owner,
  output logic [COUNT_WIDTH-1:0] grant_cnt0,
  output logic [COUNT_WIDTH-1:0] grant_cnt1
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic                   owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BLK_W-1:0]       data_q, data_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [COUNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [COUNT_WIDTH-1:0] cnt1_q, cnt1_d;
  logic [1:0]             rdy_q, rdy_d;
  logic [1:0]             hit_q, hit_d;
  logic [1:0]             bv_q, bv_d;
  logic [BLK_W-1:0]       blk0_q, blk0_d;
  logic [BLK_W-1:0]       blk1_q, blk1_d;
  logic [1:0]             elig_s;
  logic                   gnt_valid_s;
  logic                   gnt_port_s;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == {COUNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + COUNT_WIDTH'(1);
    end
  endfunction

  // A port whose completion pulse is showing is not re-granted in that cycle.
  assign elig_s[0] = (p0_read | p0_write) & ~rdy_q[0];
  assign elig_s[1] = (p1_read | p1_write) & ~rdy_q[1];

  // Grant selection, latching and response steering.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    rdy_d       = 2'b00;
    hit_d       = 2'b00;
    bv_d        = 2'b00;
    blk0_d      = blk0_q;
    blk1_d      = blk1_q;
    gnt_valid_s = 1'b0;
    gnt_port_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig_s[0] && elig_s[1]) begin
          gnt_valid_s = 1'b1;
          gnt_port_s  = rr_q;
          rr_d        = ~rr_q;
        end else if (elig_s[0]) begin
          gnt_valid_s = 1'b1;
          gnt_port_s  = 1'b0;
        end else if (elig_s[1]) begin
          gnt_valid_s = 1'b1;
          gnt_port_s  = 1'b1;
        end else begin
          gnt_valid_s = 1'b0;
        end
        if (gnt_valid_s) begin
          owner_d = gnt_port_s;
          state_d = BUSY;
          // Write wins when a requester raises both commands.
          if (gnt_port_s) begin
            addr_d = p1_addr;
            data_d = p1_data_in;
            wr_d   = p1_write;
            rd_d   = p1_read & ~p1_write;
            cnt1_d = sat_inc(cnt1_q);
          end else begin
            addr_d = p0_addr;
            data_d = p0_data_in;
            wr_d   = p0_write;
            rd_d   = p0_read & ~p0_write;
            cnt0_d = sat_inc(cnt0_q);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (l2_ready) begin
          state_d = IDLE;
          if (owner_q) begin
            rdy_d[1] = 1'b1;
            hit_d[1] = l2_hit;
            bv_d[1]  = l2_block_valid;
            blk1_d   = l2_block_data;
          end else begin
            rdy_d[0] = 1'b1;
            hit_d[0] = l2_hit;
            bv_d[0]  = l2_block_valid;
            blk0_d   = l2_block_data;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latches, counters and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      rdy_q   <= 2'b00;
      hit_q   <= 2'b00;
      bv_q    <= 2'b00;
      blk0_q  <= '0;
      blk1_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      rdy_q   <= rdy_d;
      hit_q   <= hit_d;
      bv_q    <= bv_d;
      blk0_q  <= blk0_d;
      blk1_q  <= blk1_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign owner = owner_q;
  assign l2_addr = addr_q;
  assign l2_data_out = data_q;
  // Dropped in the l2_ready cycle so the L2 does not restart while returning to idle.
  assign l2_read  = busy & rd_q & ~l2_ready;
  assign l2_write = busy & wr_q & ~l2_ready;
  assign p0_ready       = rdy_q[0];
  assign p0_hit         = hit_q[0];
  assign p0_block_valid = bv_q[0];
  assign p0_block_out   = blk0_q;
  assign p1_ready       = rdy_q[1];
  assign p1_hit         = hit_q[1];
  assign p1_block_valid = bv_q[1];
  assign p1_block_out   = blk1_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter; a second instance with 2-bit counters shares all stimulus.
module tb_l2_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 32;
  localparam int BW = BS * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [BW-1:0] p0_data_in, p1_data_in;
  logic          p0_read, p0_write, p1_read, p1_write;
  logic          l2_ready, l2_hit, l2_block_valid;
  logic [BW-1:0] l2_block_data;

  logic          p0_ready, p0_hit, p0_block_valid, p1_ready, p1_hit, p1_block_valid;
  logic [BW-1:0] p0_block_out, p1_block_out, l2_data_out;
  logic [AW-1:0] l2_addr;
  logic          l2_read, l2_write, busy, owner;
  logic [15:0]   grant_cnt0, grant_cnt1;

  logic          s_p0_ready, s_p0_hit, s_p0_bv, s_p1_ready, s_p1_hit, s_p1_bv;
  logic [BW-1:0] s_p0_blk, s_p1_blk, s_l2_data_out;
  logic [AW-1:0] s_l2_addr;
  logic          s_l2_read, s_l2_write, s_busy, s_owner;
  logic [1:0]    s_cnt0, s_cnt1;

  int errs = 0;
  int checks = 0;

  logic [BW-1:0] d1, d2, d3, d4, dm, da5, d5;

  always #5 clk = ~clk;

  l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_data_in(p0_data_in), .p0_read(p0_read), .p0_write(p0_write),
    .p0_ready(p0_ready), .p0_hit(p0_hit), .p0_block_valid(p0_block_valid), .p0_block_out(p0_block_out),
    .p1_addr(p1_addr), .p1_data_in(p1_data_in), .p1_read(p1_read), .p1_write(p1_write),
    .p1_ready(p1_ready), .p1_hit(p1_hit), .p1_block_valid(p1_block_valid), .p1_block_out(p1_block_out),
    .l2_addr(l2_addr), .l2_data_out(l2_data_out), .l2_read(l2_read), .l2_write(l2_write),
    .l2_ready(l2_ready), .l2_hit(l2_hit), .l2_block_valid(l2_block_valid), .l2_block_data(l2_block_data),
    .busy(busy), .owner(owner), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .COUNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_data_in(p0_data_in), .p0_read(p0_read), .p0_write(p0_write),
    .p0_ready(s_p0_ready), .p0_hit(s_p0_hit), .p0_block_valid(s_p0_bv), .p0_block_out(s_p0_blk),
    .p1_addr(p1_addr), .p1_data_in(p1_data_in), .p1_read(p1_read), .p1_write(p1_write),
    .p1_ready(s_p1_ready), .p1_hit(s_p1_hit), .p1_block_valid(s_p1_bv), .p1_block_out(s_p1_blk),
    .l2_addr(s_l2_addr), .l2_data_out(s_l2_data_out), .l2_read(s_l2_read), .l2_write(s_l2_write),
    .l2_ready(l2_ready), .l2_hit(l2_hit), .l2_block_valid(l2_block_valid), .l2_block_data(l2_block_data),
    .busy(s_busy), .owner(s_owner), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // L2 stand-in: after n more cycles, raise l2_ready for one cycle and check the command is gated off.
  task automatic l2_respond(input int n, input logic hit, input logic bv, input logic [BW-1:0] d);
    repeat (n) @(negedge clk);
    l2_ready = 1'b1; l2_hit = hit; l2_block_valid = bv; l2_block_data = d;
    #1;
    chk("gate_rd", {63'd0, l2_read}, 64'd0);
    chk("gate_wr", {63'd0, l2_write}, 64'd0);
    @(negedge clk);
    l2_ready = 1'b0; l2_hit = 1'b0; l2_block_valid = 1'b0;
  endtask

  initial begin
    d1  = {BS{32'h1111_0040}};
    d2  = {BS{32'h2222_0020}};
    d3  = {BS{32'h3333_0003}};
    d4  = {BS{32'h4444_0004}};
    dm  = {BS{32'hDEAD_0155}};
    da5 = {BS{32'hA5A5_A5A5}};
    d5  = {BS{32'h5555_0005}};
    rst = 1'b1;
    p0_addr = '0; p1_addr = '0; p0_data_in = '0; p1_data_in = '0;
    p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
    l2_ready = 1'b0; l2_hit = 1'b0; l2_block_valid = 1'b0; l2_block_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_l2rd", {63'd0, l2_read}, 64'd0);
    chk("rst_addr", {53'd0, l2_addr}, 64'd0);
    chk("rst_cnt0", {48'd0, grant_cnt0}, 64'd0);
    rst = 1'b0;

    // Uncontended read hit from port 0
    @(negedge clk);
    p0_addr = 11'h040; p0_read = 1'b1;
    @(negedge clk);
    chk("t1_l2rd", {63'd0, l2_read}, 64'd1);
    chk("t1_l2wr", {63'd0, l2_write}, 64'd0);
    chk("t1_addr", {53'd0, l2_addr}, 64'h040);
    chk("t1_owner", {63'd0, owner}, 64'd0);
    l2_respond(2, 1'b1, 1'b1, d1);
    chk("t1_rdy", {63'd0, p0_ready}, 64'd1);
    chk("t1_hit", {63'd0, p0_hit}, 64'd1);
    chk("t1_bv", {63'd0, p0_block_valid}, 64'd1);
    chk_blk("t1_blk", p0_block_out, d1);
    chk("t1_p1rdy", {63'd0, p1_ready}, 64'd0);
    chk_blk("t1_p1blk", p1_block_out, '0);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    p0_read = 1'b0;
    @(negedge clk);
    chk("t1_pulse", {63'd0, p0_ready}, 64'd0);
    chk_blk("t1_hold", p0_block_out, d1);
    chk("t1_cnt0", {48'd0, grant_cnt0}, 64'd1);

    // Simultaneous pair: pointer at port 0
    p0_addr = 11'h010; p0_read = 1'b1;
    p1_addr = 11'h020; p1_write = 1'b1; p1_data_in = d2;
    @(negedge clk);
    chk("p1_owner", {63'd0, owner}, 64'd0);
    chk("p1_addr", {53'd0, l2_addr}, 64'h010);
    chk("p1_l2rd", {63'd0, l2_read}, 64'd1);
    l2_respond(2, 1'b1, 1'b1, d3);
    chk("p1_rdy0", {63'd0, p0_ready}, 64'd1);
    chk("p1_rdy1", {63'd0, p1_ready}, 64'd0);
    p0_read = 1'b0;
    @(negedge clk);
    chk("p1b_owner", {63'd0, owner}, 64'd1);
    chk("p1b_l2wr", {63'd0, l2_write}, 64'd1);
    chk("p1b_l2rd", {63'd0, l2_read}, 64'd0);
    chk("p1b_addr", {53'd0, l2_addr}, 64'h020);
    chk_blk("p1b_data", l2_data_out, d2);
    l2_respond(2, 1'b1, 1'b1, d2);
    chk("p1b_rdy1", {63'd0, p1_ready}, 64'd1);
    chk_blk("p1b_blk", p1_block_out, d2);
    chk("p1b_rdy0", {63'd0, p0_ready}, 64'd0);
    p1_write = 1'b0;
    @(negedge clk);

    // Same pair again: pointer now favours port 1
    p0_read = 1'b1; p1_write = 1'b1;
    @(negedge clk);
    chk("p2_owner", {63'd0, owner}, 64'd1);
    chk("p2_l2wr", {63'd0, l2_write}, 64'd1);
    l2_respond(2, 1'b1, 1'b1, d2);
    chk("p2_rdy1", {63'd0, p1_ready}, 64'd1);
    p1_write = 1'b0;
    @(negedge clk);
    chk("p2b_owner", {63'd0, owner}, 64'd0);
    chk("p2b_l2rd", {63'd0, l2_read}, 64'd1);
    l2_respond(2, 1'b1, 1'b1, d4);
    chk("p2b_rdy0", {63'd0, p0_ready}, 64'd1);
    chk_blk("p2b_blk", p0_block_out, d4);
    p0_read = 1'b0;
    @(negedge clk);
    chk("p2_cnt0", {48'd0, grant_cnt0}, 64'd3);
    chk("p2_cnt1", {48'd0, grant_cnt1}, 64'd2);

    // Port 1 read miss with long L2 latency
    p1_addr = 11'h155; p1_read = 1'b1;
    @(negedge clk);
    chk("m_l2rd", {63'd0, l2_read}, 64'd1);
    repeat (4) @(negedge clk);
    chk("m_l2rd_wait", {63'd0, l2_read}, 64'd1);
    chk("m_busy", {63'd0, busy}, 64'd1);
    l2_respond(3, 1'b0, 1'b1, dm);
    chk("m_rdy", {63'd0, p1_ready}, 64'd1);
    chk("m_hit", {63'd0, p1_hit}, 64'd0);
    chk("m_bv", {63'd0, p1_block_valid}, 64'd1);
    chk_blk("m_blk", p1_block_out, dm);
    chk("m_rdy0", {63'd0, p0_ready}, 64'd0);
    chk_blk("m_p0hold", p0_block_out, d4);
    p1_read = 1'b0;
    @(negedge clk);

    // Read and write together: write only is forwarded
    p0_addr = 11'h0F0; p0_read = 1'b1; p0_write = 1'b1; p0_data_in = da5;
    @(negedge clk);
    chk("rw_l2wr", {63'd0, l2_write}, 64'd1);
    chk("rw_l2rd", {63'd0, l2_read}, 64'd0);
    chk_blk("rw_data", l2_data_out, da5);
    l2_respond(2, 1'b1, 1'b1, da5);
    chk("rw_rdy", {63'd0, p0_ready}, 64'd1);
    chk_blk("rw_blk", p0_block_out, da5);
    p0_read = 1'b0; p0_write = 1'b0;
    @(negedge clk);
    chk("pre_cnt0", {48'd0, grant_cnt0}, 64'd4);
    chk("pre_cnt1", {48'd0, grant_cnt1}, 64'd3);
    chk("pre_scnt0", {62'd0, s_cnt0}, 64'd3);
    chk("pre_scnt1", {62'd0, s_cnt1}, 64'd3);

    // Reset while busy abandons the transaction
    p0_addr = 11'h0AA; p0_read = 1'b1; p0_write = 1'b0;
    @(negedge clk);
    chk("r_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("r_busy0", {63'd0, busy}, 64'd0);
    chk("r_l2rd0", {63'd0, l2_read}, 64'd0);
    chk("r_addr0", {53'd0, l2_addr}, 64'd0);
    chk("r_cnt0", {48'd0, grant_cnt0}, 64'd0);
    chk_blk("r_blk0", p0_block_out, '0);
    @(negedge clk);
    rst = 1'b0;
    chk("r_rdy0", {63'd0, p0_ready}, 64'd0);
    @(negedge clk);
    chk("r_regrant", {63'd0, busy}, 64'd1);
    chk("r_l2rd", {63'd0, l2_read}, 64'd1);
    chk("r_addr", {53'd0, l2_addr}, 64'h0AA);
    l2_respond(2, 1'b1, 1'b1, d5);
    chk("r_rdy", {63'd0, p0_ready}, 64'd1);
    p0_read = 1'b0;
    @(negedge clk);

    // Four more port-0 transactions: wide counter reaches 5, narrow one stays at 3
    for (int i = 0; i < 4; i++) begin
      p0_addr = AW'(i); p0_read = 1'b1;
      @(negedge clk);
      chk("s_l2rd", {63'd0, l2_read}, 64'd1);
      l2_respond(2, 1'b1, 1'b1, d5);
      chk("s_rdy", {63'd0, p0_ready}, 64'd1);
      p0_read = 1'b0;
      @(negedge clk);
    end
    chk("s_cnt0", {48'd0, grant_cnt0}, 64'd5);
    chk("s_cnt1", {48'd0, grant_cnt1}, 64'd0);
    chk("s_sat0", {62'd0, s_cnt0}, 64'd3);
    chk("s_sat1", {62'd0, s_cnt1}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
